// File: rtl/mealy_stim_seq_if.sv
// ---------------------------------------------------------------------------
// mealy_stim_seq_if
//   Bundles the program-load handshake, playback controls, FSM drive/response
//   signals and debug taps of the Mealy-FSM stimulus sequencer.
//
//   slave  modport : the sequencer itself
//   master modport : whatever loads programs and watches results
//
//   Signals
//     load_valid / load_sym / load_ready : program append handshake
//     clear, start, auto, step_pulse     : playback controls
//     fsm_out                            : registered output of the driven FSM
//     sw_out, ctrl_out                   : FSM switch input and step strobe
//     resp_bits, resp_count              : captured responses
//     busy, done                         : playback status
//     dbg_state, dbg_len                 : sequencer state and program length
// ---------------------------------------------------------------------------
interface mealy_stim_seq_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             load_valid;
  logic [1:0]       load_sym;
  logic             load_ready;
  logic             clear;
  logic             start;
  logic             auto;
  logic             step_pulse;
  logic             fsm_out;
  logic [1:0]       sw_out;
  logic             ctrl_out;
  logic [DEPTH-1:0] resp_bits;
  logic [CW-1:0]    resp_count;
  logic             busy;
  logic             done;
  logic [2:0]       dbg_state;
  logic [CW-1:0]    dbg_len;

  modport slave (
    input  load_valid, load_sym, clear, start, auto, step_pulse, fsm_out,
    output load_ready, sw_out, ctrl_out, resp_bits, resp_count, busy, done,
           dbg_state, dbg_len
  );

  modport master (
    output load_valid, load_sym, clear, start, auto, step_pulse, fsm_out,
    input  load_ready, sw_out, ctrl_out, resp_bits, resp_count, busy, done,
           dbg_state, dbg_len
  );
endinterface

// File: rtl/mealy_stim_seq.sv
// ---------------------------------------------------------------------------
// mealy_stim_seq
//   Stimulus sequencer for the board's two-state Mealy FSM. A program of
//   2-bit symbols is appended while idle, then played out one symbol per
//   step on sw_out with a single-cycle ctrl_out strobe. The FSM's registered
//   output is captured after every strobe into resp_bits for LED display.
//
//   Ports
//     clk    : system clock
//     reset  : asynchronous active-high reset; aborts playback, loses program
//     bus    : mealy_stim_seq_if.slave (see interface header)
//
//   Parameters
//     DEPTH  : maximum program length in symbols (>= 2)
//     PERIOD : clocks each symbol dwells in SETUP when auto = 1 (>= 1)
//
//   Load handshake: a symbol is appended on a rising clock edge where
//   load_valid && load_ready. load_ready is decoded from registers only
//   (IDLE and not full), so it never depends combinationally on load_valid.
//   A clear in the same cycle suppresses the append.
//
//   State sequence per symbol: SETUP (sw_out stable, waits for step_pulse or
//   the dwell timer) -> STROBE (ctrl_out high one cycle) -> CAPTURE (FSM
//   output sampled) -> SETUP for the next symbol, or DONE after the last.
// ---------------------------------------------------------------------------
module mealy_stim_seq #(
  parameter int DEPTH  = 16,
  parameter int PERIOD = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  mealy_stim_seq_if.slave   bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD - 1);
  localparam logic [CW-1:0] LEN_FULL   = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [1:0]       r_mem [DEPTH];
  logic [CW-1:0]    r_len;
  logic [CW-1:0]    r_idx;
  logic [TW-1:0]    r_timer;
  logic [1:0]       r_sw;
  logic             r_ctrl;
  logic             r_busy;
  logic             r_done;
  logic [DEPTH-1:0] r_resp_bits;
  logic [CW-1:0]    r_resp_count;

  logic             w_rest;
  logic             w_load_ready;
  logic             w_clear;
  logic             w_load_acc;
  logic [CW-1:0]    w_eff_len;
  logic             w_start;
  logic             w_timer_hit;
  logic             w_last;
  logic             w_step_go;
  logic [CW-1:0]    w_idx_nxt;
  logic [AW-1:0]    w_idx_a;
  logic [AW-1:0]    w_idx_nxt_a;
  logic [AW-1:0]    w_wr_a;
  logic [1:0]       w_first_sym;

  // ---------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------
  // IDLE and DONE are the only states that accept clear/start.
  assign w_rest       = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_load_ready = (r_state == S_IDLE) && (r_len < LEN_FULL);
  assign w_clear      = bus.clear && w_rest;
  // Clear outranks a same-cycle append.
  assign w_load_acc   = bus.load_valid && w_load_ready && !bus.clear;
  // A symbol appended in the start cycle is part of the program played.
  assign w_eff_len    = r_len + CW'(w_load_acc);
  assign w_start      = bus.start && w_rest && !bus.clear && (w_eff_len != '0);
  assign w_timer_hit  = (r_timer == TIMER_LAST);
  assign w_last       = (r_idx == (r_len - CW'(1)));
  // auto is sampled every SETUP cycle, so switching modes mid-playback
  // applies on the next SETUP cycle without touching the timer.
  assign w_step_go    = bus.auto ? w_timer_hit : bus.step_pulse;

  assign w_idx_nxt    = r_idx + CW'(1);
  assign w_idx_a      = r_idx[AW-1:0];
  assign w_idx_nxt_a  = w_idx_nxt[AW-1:0];
  assign w_wr_a       = r_len[AW-1:0];
  // With an empty program the first symbol is the one being appended now.
  assign w_first_sym  = (r_len == '0) ? bus.load_sym : r_mem[0];

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_clear)      w_state_nxt = S_IDLE;
        else if (w_start) w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        if (w_step_go) w_state_nxt = S_STROBE;
      end
      S_STROBE:  w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = w_last ? S_DONE : S_SETUP;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State register and registered status outputs
  // ---------------------------------------------------------------------
  // ctrl_out/busy/done come straight from flops loaded from the next state,
  // so they are glitch-free and ctrl_out can only be high in STROBE, which
  // always lasts exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ctrl  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ctrl  <= (w_state_nxt == S_STROBE);
      r_busy  <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_STROBE) ||
                 (w_state_nxt == S_CAPTURE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // ---------------------------------------------------------------------
  // Datapath: length, index, dwell timer, switch drive, responses
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len        <= '0;
      r_idx        <= '0;
      r_timer      <= '0;
      r_sw         <= 2'd0;
      r_resp_bits  <= '0;
      r_resp_count <= '0;
    end else begin
      if (w_clear) begin
        r_len        <= '0;
        r_resp_bits  <= '0;
        r_resp_count <= '0;
      end else begin
        if (w_load_acc) r_len <= r_len + CW'(1);
        if (w_start) begin
          r_idx        <= '0;
          r_timer      <= '0;
          r_sw         <= w_first_sym;
          r_resp_bits  <= '0;
          r_resp_count <= '0;
        end
      end

      // The timer stops at its terminal value on leaving SETUP and is
      // cleared again when the next SETUP is entered.
      if ((r_state == S_SETUP) && bus.auto && !w_timer_hit)
        r_timer <= r_timer + TW'(1);

      // The FSM registered its output on the STROBE edge, so fsm_out is
      // valid throughout CAPTURE. sw_out advances only here, keeping it
      // stable from the first SETUP cycle through CAPTURE.
      if (r_state == S_CAPTURE) begin
        r_resp_bits[w_idx_a] <= bus.fsm_out;
        r_resp_count         <= r_resp_count + CW'(1);
        if (!w_last) begin
          r_idx   <= w_idx_nxt;
          r_timer <= '0;
          r_sw    <= r_mem[w_idx_nxt_a];
        end
      end
    end
  end

  // Program storage needs no reset: length is the validity marker.
  always_ff @(posedge clk) begin
    if (w_load_acc) r_mem[w_wr_a] <= bus.load_sym;
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.load_ready = w_load_ready;
  assign bus.sw_out     = r_sw;
  assign bus.ctrl_out   = r_ctrl;
  assign bus.resp_bits  = r_resp_bits;
  assign bus.resp_count = r_resp_count;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.dbg_state  = r_state;
  assign bus.dbg_len    = r_len;

endmodule

// File: tb/tb_mealy_stim_seq.sv
module tb_mealy_stim_seq;

  localparam int DEPTH  = 16;
  localparam int PERIOD = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;

  // -------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mealy_stim_seq_if #(.DEPTH(DEPTH)) bus ();

  mealy_stim_seq #(.DEPTH(DEPTH), .PERIOD(PERIOD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // -------------------------------------------------------------------
  // Model of the driven two-state Mealy FSM:
  //   out  <= (s == 0) && (sw == 2)
  //   s    toggles when sw == 3
  // both updated on edges where the step strobe is high.
  // -------------------------------------------------------------------
  logic fsm_s, fsm_q, fsm_preset;
  always @(posedge clk) begin
    if (fsm_preset) begin
      fsm_s <= 1'b0;
      fsm_q <= 1'b0;
    end else if (bus.ctrl_out) begin
      fsm_q <= (!fsm_s) && (bus.sw_out == 2'd2);
      if (bus.sw_out == 2'd3) fsm_s <= ~fsm_s;
    end
  end
  assign bus.fsm_out = fsm_q;

  // -------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];
  int strobe_cyc[$];
  int n_strobe = 0;
  int cyc_cnt = 0;
  logic prev_ctrl = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Every strobe must carry the next expected symbol and be isolated.
  always @(negedge clk) begin
    if (bus.ctrl_out) begin
      n_strobe++;
      strobe_cyc.push_back(cyc_cnt);
      check("ctrl_gap", {31'd0, prev_ctrl}, 32'd0);
      if (exp_q.size() == 0) check("sw_extra", 32'd1, 32'd0);
      else                   check("sw_seq", {30'd0, bus.sw_out}, {30'd0, exp_q.pop_front()});
    end
    prev_ctrl = bus.ctrl_out;
  end

  // -------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] s);
    bus.load_valid = 1'b1;
    bus.load_sym   = s;
    cyc(1);
    bus.load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  task automatic step();
    bus.step_pulse = 1'b1;
    cyc(1);
    bus.step_pulse = 1'b0;
  endtask

  task automatic preset_fsm();
    fsm_preset = 1'b1;
    cyc(1);
    fsm_preset = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (!bus.done && k < budget) begin
      cyc(1);
      k++;
    end
    check(tag, {31'd0, bus.done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // -------------------------------------------------------------------
  // Directed vectors
  // -------------------------------------------------------------------
  logic [1:0] prog16 [17];
  int t0;
  int s0;
  int dc;

  initial begin
    prog16 = '{2'd2, 2'd2, 2'd3, 2'd2, 2'd0, 2'd3, 2'd2, 2'd1,
               2'd2, 2'd3, 2'd3, 2'd2, 2'd0, 2'd2, 2'd1, 2'd2, 2'd3};
    bus.load_valid = 1'b0; bus.load_sym = 2'd0; bus.clear = 1'b0;
    bus.start = 1'b0; bus.auto = 1'b0; bus.step_pulse = 1'b0;
    reset = 1'b1; fsm_preset = 1'b1;
    cyc(2);
    reset = 1'b0; fsm_preset = 1'b0;
    cyc(1);

    // Reset state
    check("rst_state", {29'd0, bus.dbg_state}, ST_IDLE);
    check("rst_len", bus.dbg_len, 0);
    check("rst_ctrl", bus.ctrl_out, 0);
    check("rst_sw", bus.sw_out, 0);
    check("rst_resp", bus.resp_bits, 0);
    check("rst_cnt", bus.resp_count, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ready", bus.load_ready, 1);

    // Reset in the middle of a STROBE
    load(2'd1); load(2'd2); load(2'd3);
    check("t1_len", bus.dbg_len, 3);
    exp_q.push_back(2'd1);
    pulse_start();
    check("t1_busy", bus.busy, 1);
    check("t1_setup", {29'd0, bus.dbg_state}, ST_SETUP);
    step();
    check("t1_strobe", bus.ctrl_out, 1);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("t1_ctrl_async", bus.ctrl_out, 0);
    check("t1_busy0", bus.busy, 0);
    check("t1_len0", bus.dbg_len, 0);
    check("t1_ready", bus.load_ready, 1);
    check("t1_idle", {29'd0, bus.dbg_state}, ST_IDLE);
    cyc(1);
    reset = 1'b0;
    cyc(1);

    // Manual playback of [2,3,0,1]
    preset_fsm();
    load(2'd2); load(2'd3); load(2'd0); load(2'd1);
    exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    s0 = n_strobe;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        // step held through STROBE and CAPTURE must not queue a step
        bus.step_pulse = 1'b1;
        cyc(3);
        bus.step_pulse = 1'b0;
        cyc(2);
        check("t2_no_extra", n_strobe - s0, 2);
        check("t2_wait_setup", {29'd0, bus.dbg_state}, ST_SETUP);
      end else begin
        if (i == 2) begin
          pulse_start();
          check("t2_busy_start_cnt", bus.resp_count, 2);
          check("t2_busy_start_st", {29'd0, bus.dbg_state}, ST_SETUP);
        end
        step();
        cyc(2);
      end
    end
    check("t2_done", bus.done, 1);
    check("t2_busy", bus.busy, 0);
    check("t2_resp", bus.resp_bits, 32'h0001);
    check("t2_cnt", bus.resp_count, 4);
    check("t2_strobes", n_strobe - s0, 4);
    check("t2_sw_hold", bus.sw_out, 1);
    load(2'd3);
    check("t2_load_drop", bus.dbg_len, 4);

    // Clear, then start with an empty program
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    check("t3_idle", {29'd0, bus.dbg_state}, ST_IDLE);
    check("t3_len", bus.dbg_len, 0);
    check("t3_cnt", bus.resp_count, 0);
    check("t3_done", bus.done, 0);
    pulse_start();
    check("t3_empty_busy", bus.busy, 0);
    check("t3_empty_st", {29'd0, bus.dbg_state}, ST_IDLE);

    // Start together with the first load plays that symbol
    preset_fsm();
    exp_q.push_back(2'd2);
    bus.load_valid = 1'b1; bus.load_sym = 2'd2; bus.start = 1'b1;
    cyc(1);
    bus.load_valid = 1'b0; bus.start = 1'b0;
    check("t4_busy", bus.busy, 1);
    check("t4_len", bus.dbg_len, 1);
    step();
    cyc(2);
    check("t4_done", bus.done, 1);
    check("t4_cnt", bus.resp_count, 1);
    check("t4_resp", bus.resp_bits, 32'h0001);

    // Auto timing, PERIOD = 4, program [2,2,3]
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    preset_fsm();
    bus.auto = 1'b1;
    load(2'd2); load(2'd2); load(2'd3);
    exp_q.push_back(2'd2); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    strobe_cyc.delete();
    pulse_start();
    t0 = cyc_cnt;
    wait_done(40, "t5_timeout");
    dc = cyc_cnt - t0 + 1;
    check("t5_done_cyc", dc, 19);
    check("t5_nstrobe", strobe_cyc.size(), 3);
    if (strobe_cyc.size() == 3) begin
      check("t5_strobe0", strobe_cyc[0] - t0 + 1, 5);
      check("t5_strobe1", strobe_cyc[1] - t0 + 1, 11);
      check("t5_strobe2", strobe_cyc[2] - t0 + 1, 17);
    end
    check("t5_resp", bus.resp_bits, 32'h0003);

    // Fill to DEPTH, 17th append dropped, full playback
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    preset_fsm();
    for (int i = 0; i < 17; i++) begin
      load(prog16[i]);
      if (i == 14) check("t6_ready15", bus.load_ready, 1);
      if (i == 15) check("t6_ready16", bus.load_ready, 0);
    end
    check("t6_len", bus.dbg_len, 16);
    for (int i = 0; i < 16; i++) exp_q.push_back(prog16[i]);
    pulse_start();
    wait_done(200, "t6_timeout");
    check("t6_cnt", bus.resp_count, 16);
    check("t6_resp", bus.resp_bits, 32'hA943);

    // Replay from DONE clears responses first
    preset_fsm();
    for (int i = 0; i < 16; i++) exp_q.push_back(prog16[i]);
    pulse_start();
    check("t7_busy", bus.busy, 1);
    check("t7_cnt0", bus.resp_count, 0);
    check("t7_resp0", bus.resp_bits, 0);
    wait_done(200, "t7_timeout");
    check("t7_cnt", bus.resp_count, 16);
    check("t7_resp", bus.resp_bits, 32'hA943);

    // Clear and start together in DONE: clear wins
    s0 = n_strobe;
    bus.clear = 1'b1; bus.start = 1'b1;
    cyc(1);
    bus.clear = 1'b0; bus.start = 1'b0;
    check("t8_idle", {29'd0, bus.dbg_state}, ST_IDLE);
    check("t8_len", bus.dbg_len, 0);
    check("t8_busy", bus.busy, 0);
    check("t8_done", bus.done, 0);
    cyc(8);
    check("t8_no_play", n_strobe - s0, 0);

    check("q_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
